// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word on a valid/ready
// handshake and shifts it out one bit per clock with frame start/end strobes.
module piso_tx #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   shift_reg;
    logic [CNT_W-1:0]   cnt;

    logic               last_bit;
    logic               accept;
    logic [WIDTH-1:0]   shifted;
    logic [CNT_W-1:0]   cnt_inc;
    logic               load_head;
    logic               shift_head;

    assign last_bit = (state == SHIFT) && (cnt == LAST);
    // Ready only from registered state, so no combinational path from in_valid.
    assign in_ready = rst && ((state == IDLE) || last_bit);
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = cnt + CNT_W'(1);

    generate
        if (MSB_FIRST) begin : g_msb
            assign shifted    = {shift_reg[WIDTH-2:0], 1'b0};
            assign load_head  = parallel_in[WIDTH-1];
            assign shift_head = shift_reg[WIDTH-2];
        end else begin : g_lsb
            assign shifted    = {1'b0, shift_reg[WIDTH-1:1]};
            assign load_head  = parallel_in[0];
            assign shift_head = shift_reg[1];
        end
    endgenerate

    // Outputs are registered alongside the state they describe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            shift_reg    <= '0;
            cnt          <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            frame_start  <= 1'b0;
            frame_end    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state        <= SHIFT;
                        shift_reg    <= parallel_in;
                        cnt          <= '0;
                        serial_out   <= load_head;
                        serial_valid <= 1'b1;
                        frame_start  <= 1'b1;
                        frame_end    <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (last_bit) begin
                        if (accept) begin
                            // Gapless hand-off: next word's first bit follows immediately.
                            shift_reg    <= parallel_in;
                            cnt          <= '0;
                            serial_out   <= load_head;
                            serial_valid <= 1'b1;
                            frame_start  <= 1'b1;
                            frame_end    <= 1'b0;
                            busy         <= 1'b1;
                        end else begin
                            state        <= IDLE;
                            shift_reg    <= shifted;
                            cnt          <= '0;
                            serial_out   <= 1'b0;
                            serial_valid <= 1'b0;
                            frame_start  <= 1'b0;
                            frame_end    <= 1'b0;
                            busy         <= 1'b0;
                        end
                    end else begin
                        shift_reg    <= shifted;
                        cnt          <= cnt_inc;
                        serial_out   <= shift_head;
                        serial_valid <= 1'b1;
                        frame_start  <= 1'b0;
                        frame_end    <= (cnt_inc == LAST);
                        busy         <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: MSB-first and LSB-first instances share stimulus and are
// checked every cycle against a queue-of-beats model, plus literal stream checks.
module tb_piso_tx;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] parallel_in;
    logic         in_valid;

    logic m_ready, m_so, m_sv, m_fs, m_fe, m_busy;
    logic l_ready, l_so, l_sv, l_fs, l_fe, l_busy;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .parallel_in(parallel_in), .in_valid(in_valid),
        .in_ready(m_ready), .serial_out(m_so), .serial_valid(m_sv),
        .frame_start(m_fs), .frame_end(m_fe), .busy(m_busy)
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .parallel_in(parallel_in), .in_valid(in_valid),
        .in_ready(l_ready), .serial_out(l_so), .serial_valid(l_sv),
        .frame_start(l_fs), .frame_end(l_fe), .busy(l_busy)
    );

    typedef struct packed {
        logic b;
        logic s;
        logic e;
    } beat_t;

    beat_t qm[$];
    beat_t ql[$];
    beat_t cm;
    beat_t cl;
    logic  cm_v     = 1'b0;
    logic  cl_v     = 1'b0;
    logic  checking = 1'b0;

    int errors = 0;
    int checks = 0;

    // A word accepted while no beats are pending expands into W future beats.
    task automatic model_step();
        if (!rst) begin
            qm.delete();
            ql.delete();
            cm_v = 1'b0;
            cl_v = 1'b0;
        end else begin
            if (in_valid && qm.size() == 0) begin
                for (int i = 0; i < int'(W); i++) begin
                    qm.push_back('{parallel_in[W-1-i], (i == 0), (i == int'(W) - 1)});
                    ql.push_back('{parallel_in[i],     (i == 0), (i == int'(W) - 1)});
                end
            end
            if (qm.size() > 0) begin
                cm   = qm.pop_front();
                cm_v = 1'b1;
            end else begin
                cm_v = 1'b0;
            end
            if (ql.size() > 0) begin
                cl   = ql.pop_front();
                cl_v = 1'b1;
            end else begin
                cl_v = 1'b0;
            end
        end
    endtask

    always @(posedge clk) model_step();

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
        end
    endtask

    task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("m_ready", m_ready, rst && (qm.size() == 0));
            chk("m_valid", m_sv,    cm_v);
            chk("m_busy",  m_busy,  cm_v);
            chk("m_out",   m_so,    cm_v & cm.b);
            chk("m_start", m_fs,    cm_v & cm.s);
            chk("m_end",   m_fe,    cm_v & cm.e);
            chk("l_ready", l_ready, rst && (ql.size() == 0));
            chk("l_valid", l_sv,    cl_v);
            chk("l_busy",  l_busy,  cl_v);
            chk("l_out",   l_so,    cl_v & cl.b);
            chk("l_start", l_fs,    cl_v & cl.s);
            chk("l_end",   l_fe,    cl_v & cl.e);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic collect(input int n, output logic [15:0] mb, output logic [15:0] lb,
                           output logic [15:0] ms, output logic [15:0] me);
        mb = '0; lb = '0; ms = '0; me = '0;
        repeat (n) begin
            @(negedge clk);
            mb = {mb[14:0], m_so};
            lb = {lb[14:0], l_so};
            ms = {ms[14:0], m_fs};
            me = {me[14:0], m_fe};
        end
    endtask

    logic [15:0] mb, lb, ms, me;

    initial begin
        // Reset held with a word offered: nothing may be accepted.
        rst         = 1'b0;
        in_valid    = 1'b1;
        parallel_in = 4'b1111;
        step();
        checking = 1'b1;
        step();
        rst      = 1'b1;
        in_valid = 1'b0;
        step();
        step();
        @(negedge clk);
        lit("s1_idle_valid", {15'd0, m_sv}, 16'd0);
        lit("s1_idle_ready", {15'd0, m_ready}, 16'd1);

        // Single word.
        step();
        parallel_in = 4'b1010;
        in_valid    = 1'b1;
        step();
        in_valid = 1'b0;
        collect(4, mb, lb, ms, me);
        lit("s2_msb_bits", mb, 16'b1010);
        lit("s2_lsb_bits", lb, 16'b0101);
        lit("s2_start",    ms, 16'b1000);
        lit("s2_end",      me, 16'b0001);
        step();

        // Back-to-back words with the second accepted on the frame_end cycle.
        parallel_in = 4'b1101;
        in_valid    = 1'b1;
        step();
        parallel_in = 4'b0111;
        fork
            collect(8, mb, lb, ms, me);
            begin
                repeat (4) step();
                in_valid = 1'b0;
            end
        join
        lit("s3_msb_bits", mb, 16'b11010111);
        lit("s3_lsb_bits", lb, 16'b10111110);
        lit("s3_start",    ms, 16'b10001000);
        lit("s3_end",      me, 16'b00010001);
        step();

        // Bit order, and in_valid mid-word is ignored.
        parallel_in = 4'b1101;
        in_valid    = 1'b1;
        step();
        fork
            collect(4, mb, lb, ms, me);
            begin
                in_valid = 1'b0;
                step();
                parallel_in = 4'b0010;
                in_valid    = 1'b1;
                step();
                in_valid    = 1'b0;
                parallel_in = 4'b0000;
            end
        join
        lit("s4_msb_bits", mb, 16'b1101);
        lit("s4_lsb_bits", lb, 16'b1011);
        step();

        // Reset mid-word, then a clean frame.
        parallel_in = 4'b1010;
        in_valid    = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        @(negedge clk);
        lit("s5_abort_valid", {15'd0, m_sv}, 16'd0);
        lit("s5_abort_end",   {15'd0, m_fe}, 16'd0);
        lit("s5_abort_out",   {15'd0, m_so}, 16'd0);
        step();
        rst         = 1'b1;
        parallel_in = 4'b0101;
        in_valid    = 1'b1;
        step();
        in_valid = 1'b0;
        collect(4, mb, lb, ms, me);
        lit("s5_msb_bits", mb, 16'b0101);
        lit("s5_lsb_bits", lb, 16'b1010);
        lit("s5_start",    ms, 16'b1000);
        lit("s5_end",      me, 16'b0001);
        step();

        // Idle gap between words.
        parallel_in = 4'b0001;
        in_valid    = 1'b1;
        step();
        in_valid = 1'b0;
        collect(4, mb, lb, ms, me);
        lit("s6a_msb_bits", mb, 16'b0001);
        lit("s6a_lsb_bits", lb, 16'b1000);
        step();
        step();
        @(negedge clk);
        lit("s6_gap_valid", {15'd0, m_sv}, 16'd0);
        step();
        parallel_in = 4'b1000;
        in_valid    = 1'b1;
        step();
        in_valid = 1'b0;
        collect(4, mb, lb, ms, me);
        lit("s6b_msb_bits", mb, 16'b1000);
        lit("s6b_lsb_bits", lb, 16'b0001);
        lit("s6b_start",    ms, 16'b1000);
        lit("s6b_end",      me, 16'b0001);
        step();
        step();

        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in serial-out transmitter. It is the sending end of the team's shift-register family.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock.
- Drives per-bit valid plus frame start/end strobes so a downstream serial-in parallel-out receiver can reassemble the word.
- Supports gapless back-to-back words. It sits between a parallel producer (register or FSM) and a 1-bit serial link.

Parameters:
- WIDTH, 4, word width in bits (valid range 2..32).
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- parallel_in  input  WIDTH  word to transmit; sampled only on the accept edge.
- in_valid  input  1  producer has a word on parallel_in.
- in_ready  output  1  transmitter can accept a word this cycle.
- serial_out  output  1  current serial bit.
- serial_valid  output  1  serial_out carries a valid data bit.
- frame_start  output  1  high with the first bit of each word.
- frame_end  output  1  high with the last bit of each word.
- busy  output  1  a word is being shifted (equals serial_valid).

Behaviour:
- Single clock. Reset is synchronous and active-low: when rst is low at a rising edge, all registers clear.
- While rst is low after that edge:
  - state = IDLE, shift register = 0, bit counter = 0.
  - serial_out = 0, serial_valid = 0, frame_start = 0, frame_end = 0, busy = 0.
  - in_ready is forced to 0.
- Accept event: in_valid && in_ready at a rising edge.
- FSM has two states: IDLE and SHIFT.
- IDLE:
  - in_ready = 1 and serial_valid = 0.
  - On accept: load parallel_in into the shift register, clear the counter, and go to SHIFT.
- SHIFT:
  - Lasts exactly WIDTH cycles; the counter runs 0..WIDTH-1.
  - serial_out = shift_reg[WIDTH-1] if MSB_FIRST, else shift_reg[0].
  - Each edge shifts by one position (left if MSB_FIRST, else right) and fills the vacated bit with 0.
  - frame_start = 1 when counter == 0. frame_end = 1 when counter == WIDTH-1.
  - in_ready = 1 only when counter == WIDTH-1; this is the gapless hand-off window.
- End of word (counter == WIDTH-1):
  - Accept in this cycle: reload the shift register, reset the counter to 0, and stay in SHIFT. The next cycle carries the new word's first bit with frame_start = 1, with no idle gap.
  - No accept: return to IDLE, and serial_valid drops on the next cycle.
- Latency: the first bit appears in the cycle immediately after the accept edge, and the last bit WIDTH cycles after accept.
- Throughput: 1 word per WIDTH cycles when streaming.
- in_valid outside an in_ready window is ignored. The producer holds parallel_in and in_valid until accepted. parallel_in changes while not accepting have no effect.
- The handshake path is purely registered-state based: in_ready depends only on state, counter and rst, not on in_valid. There is no combinational in-to-out loop.
- Reset mid-word: the word is aborted, all outputs clear as listed above, and no partial frame_end is emitted.
- Outputs serial_out, serial_valid, frame_start and frame_end are registered or decoded from registered state only, and are glitch-free with respect to inputs.
- serial_out = 0 whenever serial_valid = 0.

Test Plan:
1. Reset: hold rst = 0 for 2 cycles with in_valid = 1 and parallel_in = 4'b1111 -> in_ready = 0, serial_valid = 0, serial_out = 0 throughout, and no word is accepted after release unless in_valid is still high.
2. Single word, MSB_FIRST = 1: accept 4'b1010 -> next 4 cycles serial_out = 1,0,1,0, frame_start on cycle 1, frame_end on cycle 4, then serial_valid = 0 and in_ready = 1.
3. Back-to-back: accept 4'b1101, keep in_valid = 1 with 4'b0111 presented during the last bit -> serial_out = 1,1,0,1,0,1,1,1 with no gap, two frame_start and two frame_end pulses, and the second accept lands exactly on the frame_end cycle.
4. Bit order, MSB_FIRST = 0: accept 4'b1101 -> serial_out = 1,0,1,1. Also present in_valid mid-word with a different value -> it is ignored (in_ready = 0) and the stream is unchanged.
5. Reset mid-word: accept 4'b1010, drop rst = 0 after 2 bits -> all outputs 0 on the next cycle and no frame_end. After release, accept 4'b0101 -> a clean 0,1,0,1 frame.
6. Idle gaps: accept 4'b0001, then wait 3 cycles before asserting in_valid with 4'b1000 -> serial_valid low during the gap, and the second frame is correct with frame_start and frame_end timing as in scenario 2.
